// File: rtl/instr_fetch_unit_pkg.sv
// Shared AVR fetch definitions: FSM state encodings, NOP and two-word opcode patterns.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   fetch_state_t  PRIME (ROM refill after reset/flush), RUN (normal), EXT (two-word presented)
//   OPC_NOP        value the ROM output registers hold after a clear
//   is_two_word()  true for LDS/STS (1001 00xd dddd 0000) and JMP/CALL (1001 010k kkkk 11xk)
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_EXT   = 2'd2
  } fetch_state_t;

  localparam logic [15:0] OPC_NOP            = 16'h0000;

  localparam logic [15:0] TW_LDS_STS_MASK    = 16'hFC0F;
  localparam logic [15:0] TW_LDS_STS_MATCH   = 16'h9000;
  localparam logic [15:0] TW_JMP_CALL_MASK   = 16'hFE0C;
  localparam logic [15:0] TW_JMP_CALL_MATCH  = 16'h940C;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & TW_LDS_STS_MASK)  == TW_LDS_STS_MATCH) ||
           ((w & TW_JMP_CALL_MASK) == TW_JMP_CALL_MATCH);
  endfunction

endpackage

// File: rtl/d_flip_flop_multi_bit_en.sv
// Generic WIDTH-bit register with load enable and synchronous active-low clear.
// Latency: 1 clk from d/en to q.
// Backpressure: none; en=0 simply holds the stored value.
//
// Ports:
//   clk    rising-edge clock
//   clr_n  synchronous clear to RST_VAL, active-low, dominates en
//   en     load d on the next rising edge
//   d      next value
//   q      stored value
module d_flip_flop_multi_bit_en #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// AVR instruction fetch: drives dual_ROM addresses, assembles {Qa,Qb} opcodes and fetches
// the extension word of two-word opcodes. Latency: 1 clk ROM read; first opcode valid 1 clk
// after PRIME. Backpressure: stall holds PC and ROM output registers; branch/skip flush to NOP.
//
// Ports:
//   clk, clr_n                 clock and synchronous active-low reset
//   stall                      decoder cannot accept the presented instruction
//   branch_en, branch_target   redirect the PC (highest priority after reset)
//   skip_en                    discard the presented instruction
//   rom_qa, rom_qb             dual_ROM registered outputs (high / low opcode byte)
//   rom_addr_a, rom_addr_b     odd / even byte address of the current PC word
//   rom_en_reg, rom_clr_reg_n  dual_ROM output register enable / clear
//   instr, instr_ext           presented opcode and its extension word (0 if single-word)
//   instr_valid                presentation valid; consumed when instr_valid & ~stall
//   instr_two_word             presented opcode is two-word
//   instr_pc, pc_next          word address of the presented opcode and of its successor
//
// The PC always points one word ahead of the word sitting in the ROM output registers,
// so in RUN the invariant pc == instr_pc + 1 holds and in EXT pc == instr_pc + 2.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 14,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                stall,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                skip_en,
  input  logic [7:0]          rom_qa,
  input  logic [7:0]          rom_qb,
  output logic [PC_WIDTH:0]   rom_addr_a,
  output logic [PC_WIDTH:0]   rom_addr_b,
  output logic                rom_en_reg,
  output logic                rom_clr_reg_n,
  output logic [15:0]         instr,
  output logic [15:0]         instr_ext,
  output logic                instr_valid,
  output logic                instr_two_word,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] pc_next
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] PC_TWO = PC_WIDTH'(2);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] instr_pc_q;
  logic [15:0]         op_hold_q;
  logic [15:0]         rom_word;
  logic                tw_det;
  logic                pc_en;
  logic                instr_pc_en;
  logic                op_hold_en;
  logic                fetch_en;
  logic                flush;

  assign rom_word = {rom_qa, rom_qb};
  assign tw_det   = is_two_word(rom_word);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  d_flip_flop_multi_bit_en #(
    .WIDTH   (PC_WIDTH),
    .RST_VAL (RESET_VECTOR)
  ) u_pc (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  // instr_pc only ever takes the current PC: the word just being loaded into the ROM
  // output registers is the one that will be presented next.
  d_flip_flop_multi_bit_en #(
    .WIDTH   (PC_WIDTH),
    .RST_VAL ('0)
  ) u_instr_pc (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (instr_pc_en),
    .d     (pc_q),
    .q     (instr_pc_q)
  );

  d_flip_flop_multi_bit_en #(
    .WIDTH   (16),
    .RST_VAL (OPC_NOP)
  ) u_op_hold (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (op_hold_en),
    .d     (rom_word),
    .q     (op_hold_q)
  );

  // ---------------------------------------------------------------------------
  // Next-state and register-enable logic
  // Priority: branch_en > skip_en > stall (reset is handled in the registers).
  // fetch_en marks every cycle in which the PC advances, so the ROM output
  // registers always track the PC; this includes the two cases that advance
  // regardless of stall (pulling in an extension word, and a skipped single-word).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q + PC_ONE;
    pc_en       = 1'b0;
    instr_pc_en = 1'b0;
    op_hold_en  = 1'b0;
    fetch_en    = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      ST_PRIME: begin
        pc_en       = 1'b1;
        instr_pc_en = 1'b1;
        fetch_en    = 1'b1;
        state_d     = ST_RUN;
      end

      ST_RUN: begin
        if (tw_det) begin
          pc_en    = 1'b1;
          fetch_en = 1'b1;
          if (skip_en) begin
            // Step past the extension word and throw away both halves.
            flush   = 1'b1;
            state_d = ST_PRIME;
          end else begin
            op_hold_en = 1'b1;
            state_d    = ST_EXT;
          end
        end else if (skip_en || !stall) begin
          pc_en       = 1'b1;
          instr_pc_en = 1'b1;
          fetch_en    = 1'b1;
        end
      end

      ST_EXT: begin
        if (!stall) begin
          pc_en       = 1'b1;
          instr_pc_en = 1'b1;
          fetch_en    = 1'b1;
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_PRIME;
      end
    endcase

    if (branch_en) begin
      pc_d        = branch_target;
      pc_en       = 1'b1;
      instr_pc_en = 1'b0;
      op_hold_en  = 1'b0;
      flush       = 1'b1;
      state_d     = ST_PRIME;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    instr          = rom_word;
    instr_ext      = OPC_NOP;
    instr_valid    = 1'b0;
    instr_two_word = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // A two-word opcode is hidden for one cycle while its extension is fetched.
        instr_valid = ~tw_det;
      end
      ST_EXT: begin
        instr          = op_hold_q;
        instr_ext      = rom_word;
        instr_valid    = 1'b1;
        instr_two_word = 1'b1;
      end
      default: begin
        instr_valid = 1'b0;
      end
    endcase
  end

  assign rom_addr_a    = {pc_q, 1'b1};
  assign rom_addr_b    = {pc_q, 1'b0};
  assign rom_en_reg    = fetch_en;
  assign rom_clr_reg_n = clr_n & ~flush;

  assign instr_pc = instr_pc_q;
  assign pc_next  = instr_pc_q + (instr_two_word ? PC_TWO : PC_ONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural dual_ROM and an opcode scoreboard.
// Latency: n/a. Backpressure: stall/skip/branch driven directly by the stimulus sequence.
module tb_instr_fetch_unit;

  logic        clk;
  logic        clr_n;
  logic        stall;
  logic        branch_en;
  logic [13:0] branch_target;
  logic        skip_en;
  logic [7:0]  rom_qa;
  logic [7:0]  rom_qb;
  logic [14:0] rom_addr_a;
  logic [14:0] rom_addr_b;
  logic        rom_en_reg;
  logic        rom_clr_reg_n;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic        instr_valid;
  logic        instr_two_word;
  logic [13:0] instr_pc;
  logic [13:0] pc_next;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] ext;
    logic        tw;
    logic [13:0] pc;
    logic [13:0] nxt;
  } exp_t;

  exp_t sbq[$];

  logic [15:0] rom_mem [0:16383];

  instr_fetch_unit #(
    .PC_WIDTH     (14),
    .RESET_VECTOR (14'h0000)
  ) dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .stall          (stall),
    .branch_en      (branch_en),
    .branch_target  (branch_target),
    .skip_en        (skip_en),
    .rom_qa         (rom_qa),
    .rom_qb         (rom_qb),
    .rom_addr_a     (rom_addr_a),
    .rom_addr_b     (rom_addr_b),
    .rom_en_reg     (rom_en_reg),
    .rom_clr_reg_n  (rom_clr_reg_n),
    .instr          (instr),
    .instr_ext      (instr_ext),
    .instr_valid    (instr_valid),
    .instr_two_word (instr_two_word),
    .instr_pc       (instr_pc),
    .pc_next        (pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual_ROM: registered outputs, clear dominates enable; Qa is the odd (high) byte.
  always @(posedge clk) begin
    if (!rom_clr_reg_n) begin
      rom_qa <= 8'h00;
      rom_qb <= 8'h00;
    end else if (rom_en_reg) begin
      rom_qa <= rom_mem[rom_addr_a[14:1]][15:8];
      rom_qb <= rom_mem[rom_addr_b[14:1]][7:0];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] op, input logic [15:0] ext, input logic tw,
                      input logic [13:0] pc, input logic [13:0] nxt);
    exp_t e;
    e.op  = op;
    e.ext = ext;
    e.tw  = tw;
    e.pc  = pc;
    e.nxt = nxt;
    sbq.push_back(e);
  endtask

  // Wait (bounded) for a valid presentation, then compare it with the scoreboard head.
  task automatic take(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 4) begin
      cyc();
      n++;
    end
    chk({tag, "/valid"}, instr_valid, 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
    end else begin
      e = '0;
    end
    chk({tag, "/instr"},    instr,          e.op);
    chk({tag, "/ext"},      instr_ext,      e.ext);
    chk({tag, "/two_word"}, instr_two_word, e.tw);
    chk({tag, "/instr_pc"}, instr_pc,       e.pc);
    chk({tag, "/pc_next"},  pc_next,        e.nxt);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = 16'h0000;
    rom_mem[1]        = 16'hE00F;
    rom_mem[2]        = 16'h940E;   // CALL
    rom_mem[3]        = 16'h0123;
    rom_mem[4]        = 16'h2400;
    rom_mem[5]        = 16'h9200;   // STS
    rom_mem[6]        = 16'h0456;
    rom_mem[7]        = 16'hE0A5;
    rom_mem[14'h0100] = 16'hE011;
    rom_mem[14'h3FFF] = 16'hE022;

    clr_n         = 1'b0;
    stall         = 1'b0;
    branch_en     = 1'b0;
    branch_target = 14'h0000;
    skip_en       = 1'b0;

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_valid",     instr_valid,    0);
    chk("rst_instr_pc",  instr_pc,       0);
    chk("rst_clr_reg_n", rom_clr_reg_n,  0);
    chk("rst_addr_a",    rom_addr_a,     15'h0001);
    chk("rst_addr_b",    rom_addr_b,     15'h0000);
    chk("rst_ext",       instr_ext,      0);
    chk("rst_two_word",  instr_two_word, 0);

    // Release: PRIME, then w0 valid after one edge
    clr_n = 1'b1;
    #1;
    chk("prime_clr_reg_n", rom_clr_reg_n, 1);
    chk("prime_valid",     instr_valid,   0);
    push(16'h0000, 16'h0000, 1'b0, 14'h0000, 14'h0001);
    cyc();
    chk("w0_first_clk", instr_valid, 1);
    take("w0");

    // Stall on w1 for three edges
    push(16'hE00F, 16'h0000, 1'b0, 14'h0001, 14'h0002);
    cyc();
    stall = 1'b1;
    #1;
    take("w1");
    for (int k = 0; k < 4; k++) begin
      chk("stall_en_reg",   rom_en_reg, 0);
      chk("stall_addr_a",   rom_addr_a, 15'h0005);
      chk("stall_instr",    instr,      16'hE00F);
      chk("stall_instr_pc", instr_pc,   14'h0001);
      if (k < 3) cyc();
    end
    stall = 1'b0;
    #1;

    // Two-word CALL: one bubble, then opcode + extension
    push(16'h940E, 16'h0123, 1'b1, 14'h0002, 14'h0004);
    cyc();
    chk("call_bubble", instr_valid, 0);
    take("call");

    push(16'h2400, 16'h0000, 1'b0, 14'h0004, 14'h0005);
    cyc();
    take("w4");

    // Skip of a two-word STS: flush, extension passed over
    cyc();
    chk("sts_bubble", instr_valid, 0);
    skip_en = 1'b1;
    #1;
    chk("skip_clr_reg_n", rom_clr_reg_n, 0);
    cyc();
    skip_en = 1'b0;
    #1;
    chk("skip_prime_valid", instr_valid, 0);
    chk("skip_prime_addr",  rom_addr_b,  15'h000E);
    push(16'hE0A5, 16'h0000, 1'b0, 14'h0007, 14'h0008);
    cyc();
    take("after_skip");

    // Branch while stalled
    stall         = 1'b1;
    branch_en     = 1'b1;
    branch_target = 14'h0100;
    #1;
    chk("br_clr_reg_n", rom_clr_reg_n, 0);
    cyc();
    branch_en = 1'b0;
    #1;
    chk("br_bubble",       instr_valid, 0);
    chk("br_prime_en_reg", rom_en_reg,  1);
    chk("br_prime_addr",   rom_addr_b,  15'h0200);
    push(16'hE011, 16'h0000, 1'b0, 14'h0100, 14'h0101);
    cyc();
    take("br_target");
    stall = 1'b0;

    // Branch to the top word, PC wraps to 0
    branch_en     = 1'b1;
    branch_target = 14'h3FFF;
    #1;
    cyc();
    branch_en = 1'b0;
    #1;
    push(16'hE022, 16'h0000, 1'b0, 14'h3FFF, 14'h0000);
    cyc();
    take("top");
    chk("wrap_addr_b", rom_addr_b, 15'h0000);
    push(16'h0000, 16'h0000, 1'b0, 14'h0000, 14'h0001);
    cyc();
    take("wrap_w0");
    push(16'hE00F, 16'h0000, 1'b0, 14'h0001, 14'h0002);
    cyc();
    take("wrap_w1");

    // Skip of a single-word while stalled still consumes it
    stall   = 1'b1;
    skip_en = 1'b1;
    #1;
    cyc();
    stall   = 1'b0;
    skip_en = 1'b0;
    #1;
    chk("skip1_bubble",   instr_valid, 0);
    chk("skip1_instr_pc", instr_pc,    14'h0002);
    push(16'h940E, 16'h0123, 1'b1, 14'h0002, 14'h0004);
    cyc();
    take("call_again");

    // Reset while holding a two-word opcode in EXT
    stall = 1'b1;
    clr_n = 1'b0;
    #1;
    chk("ext_rst_clr_reg_n", rom_clr_reg_n, 0);
    cyc();
    chk("ext_rst_valid",    instr_valid,    0);
    chk("ext_rst_instr_pc", instr_pc,       0);
    chk("ext_rst_two_word", instr_two_word, 0);
    chk("ext_rst_ext",      instr_ext,      0);
    clr_n = 1'b1;
    stall = 1'b0;
    #1;
    push(16'h0000, 16'h0000, 1'b0, 14'h0000, 14'h0001);
    cyc();
    take("restart_w0");
    push(16'hE00F, 16'h0000, 1'b0, 14'h0001, 14'h0002);
    cyc();
    take("restart_w1");

    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
